// File: rtl/uart_sram_tx_interface.sv
// uart_sram_tx_interface: reads a block of 16-bit SRAM words and sends them as 8N1 bytes, high byte first.
// Define UART_TX_CHECKSUM_EN to append a trailing XOR checksum byte to every transfer.
module uart_sram_tx_interface #(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int ADDR_W         = 18
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Start_address,
    input  logic [ADDR_W-1:0] Word_count,
    input  logic [15:0]       SRAM_read_data,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic              SRAM_we_n,
    output logic              UART_TX_O,
    output logic              Busy,
    output logic              Done
);
    localparam logic [2:0] S_TX_IDLE  = 3'd0;
    localparam logic [2:0] S_TX_ISSUE = 3'd1;
    localparam logic [2:0] S_TX_WAIT  = 3'd2;
    localparam logic [2:0] S_TX_LATCH = 3'd3;
    localparam logic [2:0] S_TX_HI    = 3'd4;
    localparam logic [2:0] S_TX_LO    = 3'd5;
`ifdef UART_TX_CHECKSUM_EN
    localparam logic [2:0] S_TX_CHK   = 3'd6;
`endif
    localparam logic [2:0] S_TX_DONE  = 3'd7;

    localparam int               CNT_W    = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] words_left;
    logic [7:0]        lo_byte;
    // Bits still to go after the start bit: data LSB first, stop bit on top.
    logic [8:0]        shift_reg;
    logic [CNT_W-1:0]  clk_cnt;
    logic [3:0]        bit_idx;
    logic              bit_end;
    logic              frame_end;
    logic              tx_active;
`ifdef UART_TX_CHECKSUM_EN
    logic [7:0]        chk_reg;
`endif

    assign bit_end   = (clk_cnt == CNT_LAST);
    assign frame_end = bit_end && (bit_idx == 4'd9);
    assign SRAM_we_n = 1'b1;
    assign Busy      = (state != S_TX_IDLE) && (state != S_TX_DONE);
    assign Done      = (state == S_TX_DONE);
`ifdef UART_TX_CHECKSUM_EN
    assign tx_active = (state == S_TX_HI) || (state == S_TX_LO) || (state == S_TX_CHK);
`else
    assign tx_active = (state == S_TX_HI) || (state == S_TX_LO);
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= S_TX_IDLE;
            SRAM_address <= '0;
            words_left   <= '0;
            lo_byte      <= '0;
            shift_reg    <= '1;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            UART_TX_O    <= 1'b1;
`ifdef UART_TX_CHECKSUM_EN
            chk_reg      <= '0;
`endif
        end else begin
            if (tx_active) begin
                if (!bit_end) begin
                    clk_cnt <= clk_cnt + 1'b1;
                end else begin
                    clk_cnt <= '0;
                    if (!frame_end) begin
                        UART_TX_O <= shift_reg[0];
                        shift_reg <= {1'b1, shift_reg[8:1]};
                        bit_idx   <= bit_idx + 1'b1;
                    end
                end
            end

            // A new byte is loaded on the same edge that ends the previous one or latches the word.
            case (state)
                S_TX_IDLE: begin
                    if (Start) begin
                        SRAM_address <= Start_address;
                        words_left   <= Word_count;
`ifdef UART_TX_CHECKSUM_EN
                        chk_reg      <= '0;
`endif
                        if (Word_count == '0) begin
`ifdef UART_TX_CHECKSUM_EN
                            UART_TX_O <= 1'b0;
                            shift_reg <= {1'b1, 8'h00};
                            clk_cnt   <= '0;
                            bit_idx   <= '0;
                            state     <= S_TX_CHK;
`else
                            state     <= S_TX_DONE;
`endif
                        end else begin
                            state <= S_TX_ISSUE;
                        end
                    end
                end
                S_TX_ISSUE: state <= S_TX_WAIT;
                S_TX_WAIT:  state <= S_TX_LATCH;
                S_TX_LATCH: begin
                    lo_byte   <= SRAM_read_data[7:0];
`ifdef UART_TX_CHECKSUM_EN
                    chk_reg   <= chk_reg ^ SRAM_read_data[15:8] ^ SRAM_read_data[7:0];
`endif
                    UART_TX_O <= 1'b0;
                    shift_reg <= {1'b1, SRAM_read_data[15:8]};
                    clk_cnt   <= '0;
                    bit_idx   <= '0;
                    state     <= S_TX_HI;
                end
                S_TX_HI: begin
                    if (frame_end) begin
                        UART_TX_O <= 1'b0;
                        shift_reg <= {1'b1, lo_byte};
                        bit_idx   <= '0;
                        state     <= S_TX_LO;
                    end
                end
                S_TX_LO: begin
                    if (frame_end) begin
                        words_left   <= words_left - 1'b1;
                        SRAM_address <= SRAM_address + 1'b1;
                        if (words_left != ADDR_W'(1)) begin
                            state <= S_TX_ISSUE;
                        end else begin
`ifdef UART_TX_CHECKSUM_EN
                            UART_TX_O <= 1'b0;
                            shift_reg <= {1'b1, chk_reg};
                            bit_idx   <= '0;
                            state     <= S_TX_CHK;
`else
                            state     <= S_TX_DONE;
`endif
                        end
                    end
                end
`ifdef UART_TX_CHECKSUM_EN
                S_TX_CHK: begin
                    if (frame_end) begin
                        state <= S_TX_DONE;
                    end
                end
`endif
                S_TX_DONE: state <= S_TX_IDLE;
                default:   state <= S_TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Bench for uart_sram_tx_interface: directed and random transfers checked every cycle
// against a byte-queue model of the serial line, Busy and Done.
module tb_uart_sram_tx_interface;
    localparam int CPB   = 4;
    localparam int AW    = 18;
    localparam int FRAME = 10 * CPB;
`ifdef UART_TX_CHECKSUM_EN
    localparam int CHKB = 1;
`else
    localparam int CHKB = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] word_cnt = '0;
    logic [15:0]   rd_data = '0;
    logic [15:0]   rd_p1 = '0;
    logic [AW-1:0] sram_addr;
    logic          we_n, tx, busy, done;
    logic [15:0]   mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    uart_sram_tx_interface #(.CLOCKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .Start_address(start_addr),
        .Word_count(word_cnt), .SRAM_read_data(rd_data), .SRAM_address(sram_addr),
        .SRAM_we_n(we_n), .UART_TX_O(tx), .Busy(busy), .Done(done)
    );

    // SRAM with data valid two clocks after the address
    always @(posedge clk) begin
        rd_p1   <= mem[sram_addr];
        rd_data <= rd_p1;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[3'(idx - 1)];
    endfunction

    // model state
    logic [7:0]    exp_q[$];
    logic [7:0]    rx_log[$];
    logic [AW-1:0] addr_log[$];
    logic          m_busy = 1'b0;
    logic          done_next = 1'b0;
    int            z_win = 0;
    logic          in_frame = 1'b0;
    int            pos = 0;
    logic [7:0]    cur_exp = '0;
    logic [7:0]    rx_byte = '0;
    int            gap = 0;
    logic          first_byte = 1'b0;
    int            fr_cnt = 0;
    int            done_cnt = 0;

    always @(negedge clk) begin
        logic          idle_c;
        logic [AW-1:0] a;
        logic [7:0]    ck;
        if (rst) begin
            chk("reset_tx", tx, 1);
            chk("reset_busy", busy, 0);
            chk("reset_done", done, 0);
            chk("reset_we_n", we_n, 1);
            exp_q.delete();
            m_busy = 0; done_next = 0; z_win = 0; in_frame = 0; pos = 0; gap = 0;
        end else begin
            idle_c = !m_busy && !done_next && (z_win == 0);
            chk("we_n", we_n, 1);
            if (z_win > 0) begin
                if (done) begin
                    chk("zero_cnt_done", done, 1);
                    done_cnt++;
                    z_win = 0;
                end else begin
                    z_win--;
                    if (z_win == 0) chk("zero_cnt_done", done, 1);
                end
            end else begin
                chk("done", done, done_next);
                chk("busy", busy, m_busy);
                if (done) done_cnt++;
            end
            done_next = 0;
            if (busy && (addr_log.size() == 0 || addr_log[addr_log.size()-1] != sram_addr))
                addr_log.push_back(sram_addr);

            if (in_frame) begin
                chk("line", tx, frame_bit(cur_exp, pos / CPB));
                if ((pos % CPB) == CPB / 2 && pos / CPB >= 1 && pos / CPB <= 8)
                    rx_byte[3'(pos / CPB - 1)] = tx;
                pos++;
                if (pos == FRAME) begin
                    in_frame = 0;
                    gap = 0;
                    rx_log.push_back(rx_byte);
                    if (exp_q.size() == 0 && m_busy) begin
                        m_busy = 0;
                        done_next = 1;
                    end
                end
            end else if (exp_q.size() == 0) begin
                chk("idle_line", tx, 1);
            end else if (tx == 1'b0) begin
                if (!first_byte) chk("byte_gap", gap <= 4, 1);
                first_byte = 0;
                cur_exp = exp_q.pop_front();
                in_frame = 1;
                pos = 1;
                fr_cnt++;
            end else begin
                gap++;
                if (gap > 8) begin
                    chk("stall", gap <= 8, 1);
                    m_busy = 0;
                    exp_q.delete();
                end
            end

            if (start && idle_c) begin
                ck = '0;
                for (int w = 0; w < int'(word_cnt); w++) begin
                    a = start_addr + AW'(w);
                    exp_q.push_back(mem[a][15:8]);
                    exp_q.push_back(mem[a][7:0]);
                    ck = ck ^ mem[a][15:8] ^ mem[a][7:0];
                end
`ifdef UART_TX_CHECKSUM_EN
                exp_q.push_back(ck);
`endif
                if (exp_q.size() == 0) begin
                    z_win = 3;
                end else begin
                    m_busy = 1;
                    gap = 0;
                    first_byte = 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] n);
        start_addr = a;
        word_cnt   = n;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
        start_addr = AW'($urandom);
        word_cnt   = AW'($urandom);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while ((m_busy || done_next || z_win != 0 || in_frame) && n < max) begin
            tick(1);
            n++;
        end
        if (n >= max) chk("idle_timeout", n, 0);
        tick(2);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

    initial begin
        int base, d0, bfr, n;
        logic [AW-1:0] ra;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
        mem[18'h00100] = 16'hA55A;
        mem[18'h00300] = 16'h1200;
        mem[18'h00400] = 16'h1234;
        mem[18'h00401] = 16'hFF00;

        // reset held, then released
        tick(5);
        rst = 1'b0;
        tick(6);

        // single word, high byte first
        base = rx_log.size(); d0 = done_cnt;
        send(18'h00100, 18'd1);
        wait_idle(400);
        chk("t2_hi_byte", rx_log[base], 8'hA5);
        chk("t2_lo_byte", rx_log[base+1], 8'h5A);
        chk("t2_done_pulses", done_cnt - d0, 1);

        // address wrap
        base = rx_log.size(); addr_log.delete();
        send(18'h3FFFF, 18'd2);
        wait_idle(600);
        chk("t3_addr0", addr_log[0], 18'h3FFFF);
        chk("t3_addr1", addr_log[1], 18'h00000);
        chk("t3_bytes", rx_log.size() - base, 4 + CHKB);

        // zero word count
        base = rx_log.size(); d0 = done_cnt;
        send(18'h00055, 18'd0);
        wait_idle(200);
        chk("t4_bytes", rx_log.size() - base, CHKB);
        chk("t4_done_pulses", done_cnt - d0, 1);
`ifdef UART_TX_CHECKSUM_EN
        chk("t4_chk_byte", rx_log[base], 8'h00);
`endif

        // Start during a transfer is ignored
        base = rx_log.size();
        send(18'h00200, 18'd3);
        tick(50);
        start_addr = 18'h01000; word_cnt = 18'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle(900);
        chk("t5_bytes", rx_log.size() - base, 6 + CHKB);

        // reset during data bit 3 of the second byte
        bfr = fr_cnt; n = 0;
        send(18'h00300, 18'd2);
        while (!(fr_cnt == bfr + 2 && pos == 4 * CPB + 2) && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("t6_reached_bit3", n < 500, 1);
        chk("t6_line_before", tx, 0);
        rst = 1'b1;
        #1;
        chk("t6_line_async", tx, 1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        tick(10);
        chk("t6_busy_after", busy, 0);
        base = rx_log.size();
        send(18'h00100, 18'd1);
        wait_idle(400);
        chk("t6_hi_byte", rx_log[base], 8'hA5);
        chk("t6_lo_byte", rx_log[base+1], 8'h5A);

`ifdef UART_TX_CHECKSUM_EN
        base = rx_log.size();
        send(18'h00400, 18'd2);
        wait_idle(600);
        chk("t7_checksum", rx_log[base+4], 8'hD9);
`endif

        // random transfers, some with a stray Start partway through
        for (int k = 0; k < 20; k++) begin
            ra = ($urandom_range(0, 3) == 0) ? AW'(18'h3FFFF - $urandom_range(0, 2)) : AW'($urandom);
            send(ra, AW'($urandom_range(1, 3)));
            if ($urandom_range(0, 1) == 1) begin
                tick($urandom_range(1, 60));
                start_addr = AW'($urandom);
                word_cnt   = AW'($urandom_range(1, 2));
                start      = 1'b1;
                tick(1);
                start      = 1'b0;
            end
            wait_idle(900);
            tick($urandom_range(0, 3));
        end

        tick(5);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
